// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding unit for a short in-order pipeline.
// Tracks the destination of the instructions in EX, MEM and WB. From that it
// produces a load-use stall, a post-redirect flush window, registered
// forwarding selects, a sticky halt state and a saturating stall counter.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   id_valid                  ID stage holds a real instruction
//   id_rs1/id_rs2             ID source specifiers
//   id_use_rs1/id_use_rs2     the source is actually read
//   id_rd                     ID destination specifier
//   id_reg_write/id_mem_read  ID control bits
//   ex_redirect               taken control transfer resolved in EX
//   halt                      HLT decoded in ID
//   stall                     hold PC and IF/ID, bubble into EX (combinational)
//   flush                     kill IF/ID this cycle
//   fwd_a/fwd_b               EX operand select: 0 rf, 1 MEM/WB, 2 EX/MEM, 3 WB latch
//   halted                    sticky halt state
//   stall_count               saturating count of load-use stall cycles
module hazard_forward_unit #(
  parameter int unsigned REG_ADDR_W        = 2,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter bit          ZERO_IS_HARDWIRED = 1'b0,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_redirect,
  input  logic                  halt,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int unsigned FC_W = 3;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

  slot_t           ex_q, mem_q, wb_q;
  slot_t           id_entry_c;
  logic [FC_W-1:0] flush_cnt_q;
  logic            load_use_c;
  logic            bubble_c;
  logic            halt_accept_c;
  logic [1:0]      fwd_a_c, fwd_b_c;
  logic            unused_c;

  // A slot supplies source src when it writes that register and src is read.
  function automatic logic slot_match(input slot_t s,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic use_src);
    return s.valid && s.reg_write && use_src && (s.rd == src) &&
           !(ZERO_IS_HARDWIRED && (src == '0));
  endfunction

  // Youngest producer wins.
  function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                         input slot_t wb_s,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic use_src);
    if (slot_match(ex_s, src, use_src))  return 2'd2;
    if (slot_match(mem_s, src, use_src)) return 2'd1;
    if (slot_match(wb_s, src, use_src))  return 2'd3;
    return 2'd0;
  endfunction

  // Only the EX slot's load flag matters; older slots already have their data.
  assign unused_c = mem_q.mem_read ^ wb_q.mem_read;

  // Stall, flush, bubble and next-entry decode.
  always_comb begin
    flush         = 1'b0;
    load_use_c    = 1'b0;
    stall         = 1'b0;
    bubble_c      = 1'b0;
    halt_accept_c = 1'b0;
    id_entry_c    = '0;
    fwd_a_c       = 2'd0;
    fwd_b_c       = 2'd0;

    flush = (flush_cnt_q != '0);
    // A redirect squashes the ID instruction, so it never stalls.
    load_use_c = id_valid && ex_q.mem_read && !flush && !halted && !ex_redirect &&
                 (slot_match(ex_q, id_rs1, id_use_rs1) ||
                  slot_match(ex_q, id_rs2, id_use_rs2));
    stall    = load_use_c || halted;
    bubble_c = stall || flush || !id_valid || ex_redirect;
    halt_accept_c = halt && id_valid && !flush && !stall && !ex_redirect;

    if (!bubble_c) begin
      id_entry_c.valid     = 1'b1;
      id_entry_c.rd        = id_rd;
      id_entry_c.reg_write = id_reg_write;
      id_entry_c.mem_read  = id_mem_read;
      fwd_a_c = fwd_sel(ex_q, mem_q, wb_q, id_rs1, id_use_rs1);
      fwd_b_c = fwd_sel(ex_q, mem_q, wb_q, id_rs2, id_use_rs2);
    end
  end

  // Pipeline slot shift; keeps draining while halted since bubbles enter EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= id_entry_c;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Flush window; a new redirect reloads rather than extends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q <= '0;
    end else if (ex_redirect) begin
      flush_cnt_q <= FLUSH_LOAD;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_q <= flush_cnt_q - FC_W'(1);
    end
  end

  // Forward selects, sticky halt and saturating stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a       <= 2'd0;
      fwd_b       <= 2'd0;
      halted      <= 1'b0;
      stall_count <= '0;
    end else begin
      fwd_a <= fwd_a_c;
      fwd_b <= fwd_b_c;
      if (halt_accept_c) halted <= 1'b1;
      if (load_use_c && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a per-cycle vector table plus
// hand-written sequences for saturation, halt and reset corner cases.
// u0 treats register 0 as ordinary, u1 as hardwired zero.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [1:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       ex_redirect, halt;

  logic       stall0, flush0, halted0, stall1, flush1, halted1;
  logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
  logic [2:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(2), .FLUSH_CYCLES(2), .ZERO_IS_HARDWIRED(1'b0), .CNT_W(3)) u0 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .halt(halt), .stall(stall0), .flush(flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
    .halted(halted0), .stall_count(cnt0));

  hazard_forward_unit #(.REG_ADDR_W(2), .FLUSH_CYCLES(2), .ZERO_IS_HARDWIRED(1'b1), .CNT_W(3)) u1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
    .halt(halt), .stall(stall1), .flush(flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .halted(halted1), .stall_count(cnt1));

  // One row per cycle: inputs applied that cycle, outputs seen that cycle.
  typedef struct {
    logic       v;
    logic [1:0] rs1;
    logic       u1;
    logic [1:0] rs2;
    logic       u2;
    logic [1:0] rd;
    logic       rw, mr, redir;
    logic       st, fl;
    logic [1:0] fa, fb;
    logic [2:0] cnt;
    logic [1:0] fa1;
    logic       st1;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, return at the falling edge.
  task automatic cycle(input logic v, input logic [1:0] rs1, input logic u1,
                       input logic [1:0] rs2, input logic u2, input logic [1:0] rd,
                       input logic rw, input logic mr, input logic redir, input logic hlt);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_redirect = redir; halt = hlt;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall0), 0);
    check({tag, "_flush"}, 32'(flush0), 0);
    check({tag, "_fwd_a"}, 32'(fwd_a0), 0);
    check({tag, "_fwd_b"}, 32'(fwd_b0), 0);
    check({tag, "_halted"}, 32'(halted0), 0);
    check({tag, "_cnt"}, 32'(cnt0), 0);
  endtask

  initial begin
    //             v rs1 u1 rs2 u2 rd rw mr rd | st fl fa fb cnt fa1 st1
    tbl[0]  = '{1, 2, 1, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}; // ADD r1
    tbl[1]  = '{1, 1, 1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}; // uses r1, 1 apart
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 0, 2, 0};
    tbl[3]  = '{1, 3, 1, 1, 1, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}; // r3 2 apart, r1 3 apart
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}; // r2 again (EX) vs WB r2
    tbl[6]  = '{1, 2, 1, 2, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}; // writes r0
    tbl[7]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2, 2, 0, 2, 0}; // reads r0
    tbl[8]  = '{1, 1, 1, 0, 0, 2, 1, 1, 0,  0, 0, 2, 0, 0, 0, 0}; // LWD r2
    tbl[9]  = '{1, 0, 0, 2, 1, 3, 1, 0, 0,  1, 0, 0, 0, 0, 0, 1}; // load-use on rs2
    tbl[10] = '{1, 0, 0, 2, 1, 3, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0}; // held consumer
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0}; // LWD r1
    tbl[13] = '{1, 1, 1, 0, 0, 2, 1, 0, 1,  0, 0, 0, 0, 1, 0, 0}; // load-use + redirect
    tbl[14] = '{1, 1, 1, 0, 0, 2, 1, 0, 1,  0, 1, 0, 0, 1, 0, 0}; // re-redirect in flush 1
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0}; // single redirect
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0};
    tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0};
    tbl[22] = '{1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0}; // LWD r0
    tbl[23] = '{1, 0, 1, 0, 0, 3, 1, 0, 0,  1, 0, 0, 0, 1, 0, 0}; // r0 load-use: u0 only
    tbl[24] = '{1, 0, 1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 2, 0, 0};
    tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2, 0, 0};
    tbl[26] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0};
    tbl[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0};

    reset_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_redirect = 0; halt = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].redir, 1'b0);
      check($sformatf("v%0d_stall", i), 32'(stall0), 32'(tbl[i].st));
      check($sformatf("v%0d_flush", i), 32'(flush0), 32'(tbl[i].fl));
      check($sformatf("v%0d_fwd_a", i), 32'(fwd_a0), 32'(tbl[i].fa));
      check($sformatf("v%0d_fwd_b", i), 32'(fwd_b0), 32'(tbl[i].fb));
      check($sformatf("v%0d_cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
      check($sformatf("v%0d_zfwd_a", i), 32'(fwd_a1), 32'(tbl[i].fa1));
      check($sformatf("v%0d_zstall", i), 32'(stall1), 32'(tbl[i].st1));
    end

    // Repeated load-use pairs drive the 3-bit counter to 7 and hold it there.
    for (int k = 0; k < 7; k++) begin
      cycle(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
      check($sformatf("sat%0d_stall", k), 32'(stall0), 1);
      cycle(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
      check($sformatf("sat%0d_cnt", k), 32'(cnt0), (k + 3 > 7) ? 7 : k + 3);
    end

    // HLT accepted, then held stalled while the pipe drains.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("hlt_stall", 32'(stall0), 0);
    check("hlt_halted_pre", 32'(halted0), 0);
    cycle(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    check("hlt_halted", 32'(halted0), 1);
    check("hlt_stall_held", 32'(stall0), 1);
    cycle(1, 1, 1, 0, 0, 2, 1, 0, 1, 0);
    check("hlt_stall_held2", 32'(stall0), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("hlt_flush", 32'(flush0), 1);
    check("hlt_cnt", 32'(cnt0), 7);
    check("hlt_fwd_a", 32'(fwd_a0), 0);
    // Reset mid-flush while halted: outputs clear without waiting for an edge.
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_halt");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // Reset in the middle of a load-use stall.
    cycle(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    check("lu_stall", 32'(stall0), 1);
    #2 reset_n = 1'b0;
    #1 check("rst_lu_stall", 32'(stall0), 0);
    check("rst_lu_cnt", 32'(cnt0), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    // Cold start: the abandoned load must not stall or forward.
    cycle(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    check("cold_stall", 32'(stall0), 0);
    check("cold_flush", 32'(flush0), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("cold_fwd_a", 32'(fwd_a0), 0);
    check("cold_cnt", 32'(cnt0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
